// File: rtl/four_bit_adder_reg.sv
// Registered ripple-carry adder with carry in/out and status flags.
// One cycle of latency; outputs hold while in_valid is low.
module four_bit_adder_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid,
    output logic             zero,
    output logic             ovf
);

    // c[i] is the carry into bit i; c[WIDTH] leaves the MSB
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             zero_c;
    logic             ovf_c;

    assign c[0] = cin;

    // Full-adder cells chained LSB to MSB
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign p[i]     = a[i] ^ b[i];
        assign g[i]     = a[i] & b[i];
        assign sum_c[i] = p[i] ^ c[i];
        assign c[i+1]   = g[i] | (c[i] & p[i]);
    end

    // Flags come from the sum that is about to be registered
    assign zero_c = (sum_c == '0);
    assign ovf_c  = c[WIDTH] ^ c[WIDTH-1];

    // Capture result on accepted operands, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
            zero <= 1'b1;
            ovf  <= 1'b0;
        end else if (in_valid) begin
            s    <= sum_c;
            cout <= c[WIDTH];
            zero <= zero_c;
            ovf  <= ovf_c;
        end
    end

    // Valid qualifier follows in_valid by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_four_bit_adder_reg.sv
// Self-checking bench for four_bit_adder_reg.
// Directed vector table, corner sequences and exhaustive sweep.
module tb_four_bit_adder_reg;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       out_valid;
    logic       zero;
    logic       ovf;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       cout;
        logic       zero;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    four_bit_adder_reg #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [4:0] act,
                       input logic [4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [3:0] ta, input logic [3:0] tb_,
                         input logic tc, input logic tv);
        @(negedge clk);
        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = tv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " s"}, {1'b0, s}, 5'd0);
        chk({nm, " cout"}, {4'd0, cout}, 5'd0);
        chk({nm, " zero"}, {4'd0, zero}, 5'd1);
        chk({nm, " ovf"}, {4'd0, ovf}, 5'd0);
        chk({nm, " out_valid"}, {4'd0, out_valid}, 5'd0);
    endtask

    initial begin
        int sum;
        logic [3:0] es;
        logic eo;
        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{4'd7,  4'd2,  1'b0, 4'b1001, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{4'd5,  4'd8,  1'b0, 4'b1101, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'd9,  4'd11, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{4'd2,  4'd2,  1'b1, 4'b0101, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{4'd15, 4'd0,  1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{4'd8,  4'd8,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b1};

        rst_n    = 1'b1;
        in_valid = 1'b1;
        a        = 4'd6;
        b        = 4'd9;
        cin      = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("reset");

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
            chk($sformatf("vec%0d s", i), {1'b0, s}, {1'b0, vecs[i].s});
            chk($sformatf("vec%0d cout", i), {4'd0, cout},
                {4'd0, vecs[i].cout});
            chk($sformatf("vec%0d zero", i), {4'd0, zero},
                {4'd0, vecs[i].zero});
            chk($sformatf("vec%0d ovf", i), {4'd0, ovf},
                {4'd0, vecs[i].ovf});
            chk($sformatf("vec%0d valid", i), {4'd0, out_valid}, 5'd1);
        end

        apply(4'd3, 4'd4, 1'b0, 1'b1);
        chk("hold load s", {1'b0, s}, 5'd7);
        chk("hold load valid", {4'd0, out_valid}, 5'd1);
        apply(4'd15, 4'd15, 1'b0, 1'b0);
        chk("hold s", {1'b0, s}, 5'd7);
        chk("hold cout", {4'd0, cout}, 5'd0);
        chk("hold zero", {4'd0, zero}, 5'd0);
        chk("hold valid", {4'd0, out_valid}, 5'd0);
        apply(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
        chk("hold x s", {1'b0, s}, 5'd7);
        chk("hold x cout", {4'd0, cout}, 5'd0);
        chk("hold x ovf", {4'd0, ovf}, 5'd0);

        apply(4'd1, 4'd2, 1'b0, 1'b1);
        chk("mid pre s", {1'b0, s}, 5'd3);
        @(negedge clk);
        a        = 4'd5;
        b        = 4'd5;
        cin      = 1'b0;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mid async");
        @(posedge clk);
        #1;
        chk_reset("mid held");
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'd1, 4'd1, 1'b0, 1'b1);
        chk("post rst s", {1'b0, s}, 5'd2);
        chk("post rst valid", {4'd0, out_valid}, 5'd1);

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    apply(ai[3:0], bi[3:0], ci[0], 1'b1);
                    sum = ai + bi + ci;
                    es  = sum[3:0];
                    eo  = (ai[3] == bi[3]) && (es[3] != ai[3]);
                    chk($sformatf("ex %0d+%0d+%0d sum", ai, bi, ci),
                        {cout, s}, sum[4:0]);
                    chk($sformatf("ex %0d+%0d+%0d zero", ai, bi, ci),
                        {4'd0, zero}, {4'd0, es == 4'd0});
                    chk($sformatf("ex %0d+%0d+%0d ovf", ai, bi, ci),
                        {4'd0, ovf}, {4'd0, eo});
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/four_bit_adder_reg.md
Name: four_bit_adder_reg

Overview:
Registered 4-bit ripple-carry adder with carry-in and carry-out, plus status flags. It is the arithmetic leaf used by datapath blocks that need an unsigned add with carry chaining. The sum is formed combinationally from a chain of full-adder cells and captured in output registers. This gives one clock of latency and a valid qualifier.

Parameters:
WIDTH, 4, operand/sum width in bits. The default of 4 is the supported configuration; any value of 1 or more must elaborate.

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  asynchronous reset, active low
in_valid  input  1  operands valid this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
cin  input  1  carry-in
s  output  WIDTH  registered sum, (a+b+cin) mod 2^WIDTH
cout  output  1  registered carry-out from the MSB
out_valid  output  1  s/cout/flags correspond to an accepted operand set
zero  output  1  registered, high when s == 0
ovf  output  1  registered signed overflow, carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Datapath structure: a ripple chain of WIDTH full-adder cells. Each cell computes sum_i = a_i ^ b_i ^ c_i and c_{i+1} = a_i&b_i | c_i&(a_i^b_i). c_0 = cin and cout = c_WIDTH. No behavioural "+" in the core.
- Full result: {cout, s} == a + b + cin exactly, as a (WIDTH+1)-bit unsigned value.
- Latency: 1 cycle. If in_valid=1 at rising edge N, then s, cout, zero, ovf and out_valid=1 are visible after edge N.
- If in_valid=0 at an edge, out_valid drops to 0 and s/cout/zero/ovf hold their previous values.
- No backpressure. A new operand set is accepted every cycle that in_valid=1.
- Reset: while rst_n=0, immediately and regardless of clk, s=0, cout=0, ovf=0, out_valid=0 and zero=1. zero=1 is consistent with s=0.
- First valid edge after rst_n deasserts captures normally. Reset asserted mid-stream discards the pending result. out_valid is never 1 during reset.
- Wrap-around: a result ≥ 2^WIDTH sets cout=1, and s holds the low WIDTH bits.
- Maximum case: a=b=all-ones, cin=1 gives s=all-ones, cout=1.
- zero is derived from the registered sum value. It is not set by cout alone, e.g. 8+8 gives s=0000, cout=1, zero=1.
- ovf treats the operands as two's complement. It is independent of cout.
- X on the operands while in_valid=0 must not propagate into the held outputs.

Test Plan:
- Reset: assert rst_n=0 with arbitrary inputs -> s=0000, cout=0, out_valid=0, zero=1, without any clock edge.
- Sequential vectors with in_valid=1, one per cycle:
  - a=0, b=0, cin=0 -> s=0000, cout=0, zero=1
  - a=7, b=2, cin=0 -> s=1001, cout=0, ovf=1
  - a=5, b=8, cin=0 -> s=1101, cout=0
  - a=9, b=11, cin=0 -> s=0100, cout=1
  - a=2, b=2, cin=1 -> s=0101, cout=0
  Each result appears one cycle after its operands.
- Carry boundary:
  - a=15, b=15, cin=1 -> s=1111, cout=1
  - a=15, b=0, cin=1 -> s=0000, cout=1, zero=1
  - a=8, b=8, cin=0 -> s=0000, cout=1, ovf=1
- Hold: apply in_valid=1 with a=3, b=4, then in_valid=0 with a=15, b=15 -> out_valid goes 1 then 0, and s stays 0111.
- Reset mid-stream: drop rst_n between two valid cycles -> outputs return to reset values asynchronously. After release, the next valid a=1, b=1 gives s=0010 one cycle later.
- Exhaustive: all 512 combinations of a, b, cin -> {cout, s} == a+b+cin, and zero and ovf match the reference model for every combination.
